// File: rtl/fpu_ss_commit_buffer.sv
// fpu_ss_commit_buffer
// Holds issued FPU instructions in program order until the core commits or
// kills them. Committed heads are presented downstream; killed heads are
// dropped without ever raising out_valid_o.

module fpu_ss_commit_buffer #(
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [95:0]                in_rs_i,
  input  logic [31:0]                in_instr_i,
  input  logic [ID_WIDTH-1:0]        in_id_i,
  input  logic [1:0]                 in_mode_i,
  input  logic                       commit_valid_i,
  input  logic [ID_WIDTH-1:0]        commit_id_i,
  input  logic                       commit_kill_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [95:0]                out_rs_o,
  output logic [31:0]                out_instr_o,
  output logic [ID_WIDTH-1:0]        out_id_o,
  output logic [1:0]                 out_mode_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int NID = 1 << ID_WIDTH;
  localparam logic [AW:0] PTR_ONE = 1;

  // Pointers carry an extra wrap bit so full and empty can be told apart.
  logic [AW:0]         r_wrPtr;
  logic [AW:0]         r_rdPtr;

  logic [95:0]         r_rs    [DEPTH];
  logic [31:0]         r_instr [DEPTH];
  logic [ID_WIDTH-1:0] r_id    [DEPTH];
  logic [1:0]          r_mode  [DEPTH];

  // One commit and one kill flag per possible id, independent of slot.
  logic [NID-1:0]      r_committed;
  logic [NID-1:0]      r_killed;

  logic [AW-1:0]       w_wrIdx;
  logic [AW-1:0]       w_rdIdx;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_drop;
  logic                w_deq;
  logic [ID_WIDTH-1:0] w_headId;
  logic                w_headCommitted;
  logic                w_headKilled;

  assign w_wrIdx = r_wrPtr[AW-1:0];
  assign w_rdIdx = r_rdPtr[AW-1:0];
  assign w_full  = (w_wrIdx == w_rdIdx) && (r_wrPtr[AW] != r_rdPtr[AW]);
  assign w_empty = (r_wrPtr == r_rdPtr);

  assign w_headId        = r_id[w_rdIdx];
  assign w_headCommitted = !w_empty && r_committed[w_headId];
  assign w_headKilled    = !w_empty && r_killed[w_headId];

  // Kill outranks commit; a killed head is dropped without waiting for out_ready_i.
  assign out_valid_o = w_headCommitted && !w_headKilled;
  assign w_pop       = out_valid_o && out_ready_i;
  assign w_drop      = w_headKilled;
  assign w_deq       = w_pop || w_drop;

  // in_ready_o depends on registered pointers only, so a pop while full frees
  // the slot for the following cycle rather than the current one.
  assign in_ready_o = !w_full;
  assign w_push     = in_valid_i && !w_full;

  assign out_rs_o    = r_rs[w_rdIdx];
  assign out_instr_o = r_instr[w_rdIdx];
  assign out_id_o    = w_headId;
  assign out_mode_o  = r_mode[w_rdIdx];

  assign count_o = r_wrPtr - r_rdPtr;

  // Payload storage: written on push, contents meaningless until pushed.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_rs[w_wrIdx]    <= in_rs_i;
      r_instr[w_wrIdx] <= in_instr_i;
      r_id[w_wrIdx]    <= in_id_i;
      r_mode[w_wrIdx]  <= in_mode_i;
    end
  end

  // Advance write pointer on push and read pointer on pop or drop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_deq)  r_rdPtr <= r_rdPtr + PTR_ONE;
    end
  end

  // Clear the head's flags when it leaves; a same-cycle set for that id comes
  // later in the block so it wins, as it belongs to a new instance of the id.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_committed <= '0;
      r_killed    <= '0;
    end else begin
      if (w_deq) begin
        r_committed[w_headId] <= 1'b0;
        r_killed[w_headId]    <= 1'b0;
      end
      if (commit_valid_i) begin
        if (commit_kill_i) r_killed[commit_id_i]    <= 1'b1;
        else               r_committed[commit_id_i] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpu_ss_commit_buffer.sv
// tb_fpu_ss_commit_buffer
// Directed scenarios against fpu_ss_commit_buffer with DEPTH=4, ID_WIDTH=4.
// Inputs change and outputs are sampled 1ns after each rising clock edge.

module tb_fpu_ss_commit_buffer;

  logic        clk_i;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [95:0] in_rs_i;
  logic [31:0] in_instr_i;
  logic [3:0]  in_id_i;
  logic [1:0]  in_mode_i;
  logic        commit_valid_i;
  logic [3:0]  commit_id_i;
  logic        commit_kill_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [95:0] out_rs_o;
  logic [31:0] out_instr_o;
  logic [3:0]  out_id_o;
  logic [1:0]  out_mode_o;
  logic [2:0]  count_o;

  int nChecks = 0;
  int nPass   = 0;

  fpu_ss_commit_buffer #(.DEPTH(4), .ID_WIDTH(4)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_rs_i        (in_rs_i),
    .in_instr_i     (in_instr_i),
    .in_id_i        (in_id_i),
    .in_mode_i      (in_mode_i),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_rs_o       (out_rs_o),
    .out_instr_o    (out_instr_o),
    .out_id_o       (out_id_o),
    .out_mode_o     (out_mode_o),
    .count_o        (count_o)
  );

  // Free-running 10ns clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [95:0] rsOf(input logic [31:0] instr);
    return {~instr, instr + 32'd1, instr};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    in_valid_i     = 1'b0;
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
    out_ready_i    = 1'b0;
  endtask

  task automatic drivePush(input logic [3:0] id, input logic [31:0] instr);
    in_valid_i = 1'b1;
    in_id_i    = id;
    in_instr_i = instr;
    in_rs_i    = rsOf(instr);
    in_mode_i  = id[1:0];
  endtask

  task automatic driveCommit(input logic [3:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
  endtask

  task automatic test_reset();
    #3;
    nChecks++; if (count_o !== 3'd0) $display("[TB] FAIL rst_count: got %0h expected 0", count_o); else nPass++;
    nChecks++; if (out_valid_o !== 1'b0) $display("[TB] FAIL rst_valid: got %0h expected 0", out_valid_o); else nPass++;
    nChecks++; if (in_ready_o !== 1'b1) $display("[TB] FAIL rst_ready: got %0h expected 1", in_ready_o); else nPass++;
    #4 rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_pass_through();
    idle();
    drivePush(4'd3, 32'h00B57053);
    driveCommit(4'd3, 1'b0);
    tick();
    nChecks++; if (out_valid_o !== 1'b1) $display("[TB] FAIL pt_valid: got %0h expected 1", out_valid_o); else nPass++;
    nChecks++; if (out_id_o !== 4'd3) $display("[TB] FAIL pt_id: got %0h expected 3", out_id_o); else nPass++;
    nChecks++; if (out_instr_o !== 32'h00B57053) $display("[TB] FAIL pt_instr: got %0h expected 00b57053", out_instr_o); else nPass++;
    nChecks++; if (out_rs_o !== rsOf(32'h00B57053)) $display("[TB] FAIL pt_rs: got %0h expected %0h", out_rs_o, rsOf(32'h00B57053)); else nPass++;
    nChecks++; if (out_mode_o !== 2'd3) $display("[TB] FAIL pt_mode: got %0h expected 3", out_mode_o); else nPass++;
    nChecks++; if (count_o !== 3'd1) $display("[TB] FAIL pt_count1: got %0h expected 1", count_o); else nPass++;
    idle();
    out_ready_i = 1'b1;
    tick();
    nChecks++; if (count_o !== 3'd0) $display("[TB] FAIL pt_count0: got %0h expected 0", count_o); else nPass++;
    nChecks++; if (out_valid_o !== 1'b0) $display("[TB] FAIL pt_valid0: got %0h expected 0", out_valid_o); else nPass++;
    idle();
  endtask

  task automatic test_kill_drop();
    idle();
    drivePush(4'd1, 32'h11110001);
    tick();
    nChecks++; if (out_valid_o !== 1'b0) $display("[TB] FAIL kd_wait: got %0h expected 0", out_valid_o); else nPass++;
    idle();
    drivePush(4'd2, 32'h22220002);
    driveCommit(4'd1, 1'b1);
    out_ready_i = 1'b1;
    tick();
    nChecks++; if (out_valid_o !== 1'b0) $display("[TB] FAIL kd_hidden: got %0h expected 0", out_valid_o); else nPass++;
    nChecks++; if (count_o !== 3'd2) $display("[TB] FAIL kd_count2: got %0h expected 2", count_o); else nPass++;
    idle();
    driveCommit(4'd2, 1'b0);
    out_ready_i = 1'b1;
    tick();
    nChecks++; if (out_valid_o !== 1'b1) $display("[TB] FAIL kd_valid: got %0h expected 1", out_valid_o); else nPass++;
    nChecks++; if (out_id_o !== 4'd2) $display("[TB] FAIL kd_id: got %0h expected 2", out_id_o); else nPass++;
    nChecks++; if (out_instr_o !== 32'h22220002) $display("[TB] FAIL kd_instr: got %0h expected 22220002", out_instr_o); else nPass++;
    nChecks++; if (count_o !== 3'd1) $display("[TB] FAIL kd_count1: got %0h expected 1", count_o); else nPass++;
    idle();
    out_ready_i = 1'b1;
    tick();
    nChecks++; if (count_o !== 3'd0) $display("[TB] FAIL kd_count0: got %0h expected 0", count_o); else nPass++;
    idle();
  endtask

  task automatic test_late_commit();
    idle();
    drivePush(4'd5, 32'h55550005);
    tick();
    for (int c = 1; c <= 6; c++) begin
      nChecks++; if (out_valid_o !== 1'b0) $display("[TB] FAIL lc_wait%0d: got %0h expected 0", c, out_valid_o); else nPass++;
      idle();
      out_ready_i = 1'b1;
      if (c == 1) drivePush(4'd6, 32'h66660006);
      if (c == 2) driveCommit(4'd6, 1'b0);
      if (c == 6) driveCommit(4'd5, 1'b0);
      tick();
    end
    nChecks++; if (out_valid_o !== 1'b1 || out_id_o !== 4'd5) $display("[TB] FAIL lc_first: got valid %0h id %0h expected valid 1 id 5", out_valid_o, out_id_o); else nPass++;
    idle();
    out_ready_i = 1'b1;
    tick();
    nChecks++; if (out_valid_o !== 1'b1 || out_id_o !== 4'd6) $display("[TB] FAIL lc_second: got valid %0h id %0h expected valid 1 id 6", out_valid_o, out_id_o); else nPass++;
    idle();
    out_ready_i = 1'b1;
    tick();
    nChecks++; if (count_o !== 3'd0) $display("[TB] FAIL lc_count0: got %0h expected 0", count_o); else nPass++;
    idle();
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 4; i++) begin
      idle();
      drivePush(4'(i), 32'hA0000000 + 32'(i));
      tick();
    end
    nChecks++; if (in_ready_o !== 1'b0) $display("[TB] FAIL fw_full_ready: got %0h expected 0", in_ready_o); else nPass++;
    nChecks++; if (count_o !== 3'd4) $display("[TB] FAIL fw_full_count: got %0h expected 4", count_o); else nPass++;
    nChecks++; if (out_valid_o !== 1'b0) $display("[TB] FAIL fw_full_valid: got %0h expected 0", out_valid_o); else nPass++;
    idle();
    driveCommit(4'd0, 1'b0);
    out_ready_i = 1'b1;
    drivePush(4'd4, 32'hA0000004);
    tick();
    nChecks++; if (out_valid_o !== 1'b1 || out_id_o !== 4'd0) $display("[TB] FAIL fw_head0: got valid %0h id %0h expected valid 1 id 0", out_valid_o, out_id_o); else nPass++;
    nChecks++; if (in_ready_o !== 1'b0) $display("[TB] FAIL fw_popfull_ready: got %0h expected 0", in_ready_o); else nPass++;
    commit_valid_i = 1'b0;
    tick();
    nChecks++; if (in_ready_o !== 1'b1) $display("[TB] FAIL fw_freed_ready: got %0h expected 1", in_ready_o); else nPass++;
    nChecks++; if (count_o !== 3'd3) $display("[TB] FAIL fw_freed_count: got %0h expected 3", count_o); else nPass++;
    out_ready_i = 1'b0;
    tick();
    nChecks++; if (count_o !== 3'd4) $display("[TB] FAIL fw_refill_count: got %0h expected 4", count_o); else nPass++;
    for (int k = 1; k <= 3; k++) begin
      idle();
      driveCommit(4'(k), 1'b0);
      tick();
      nChecks++; if (out_valid_o !== 1'b1 || out_id_o !== 4'(k)) $display("[TB] FAIL fw_head%0d: got valid %0h id %0h expected valid 1 id %0d", k, out_valid_o, out_id_o, k); else nPass++;
      nChecks++; if (in_ready_o !== 1'b0) $display("[TB] FAIL fw_ready%0d: got %0h expected 0", k, in_ready_o); else nPass++;
      idle();
      out_ready_i = 1'b1;
      drivePush(4'(4 + k), 32'hA0000000 + 32'(4 + k));
      tick();
      nChecks++; if (in_ready_o !== 1'b1 || count_o !== 3'd3) $display("[TB] FAIL fw_slot%0d: got ready %0h count %0h expected ready 1 count 3", k, in_ready_o, count_o); else nPass++;
      out_ready_i = 1'b0;
      tick();
      nChecks++; if (count_o !== 3'd4) $display("[TB] FAIL fw_count%0d: got %0h expected 4", k, count_o); else nPass++;
    end
    for (int j = 0; j <= 4; j++) begin
      if (j > 0) begin
        nChecks++;
        if (out_valid_o !== 1'b1 || out_id_o !== 4'(3 + j) || out_instr_o !== 32'hA0000000 + 32'(3 + j))
          $display("[TB] FAIL fw_drain%0d: got valid %0h id %0h instr %0h expected valid 1 id %0d instr %0h",
                   j, out_valid_o, out_id_o, out_instr_o, 3 + j, 32'hA0000000 + 32'(3 + j));
        else nPass++;
      end
      idle();
      out_ready_i = 1'b1;
      if (j < 4) driveCommit(4'(4 + j), 1'b0);
      tick();
    end
    nChecks++; if (count_o !== 3'd0 || out_valid_o !== 1'b0) $display("[TB] FAIL fw_empty: got count %0h valid %0h expected 0 0", count_o, out_valid_o); else nPass++;
    idle();
  endtask

  task automatic test_backpressure();
    idle();
    drivePush(4'd9, 32'h99990009);
    driveCommit(4'd9, 1'b0);
    tick();
    for (int b = 1; b <= 5; b++) begin
      nChecks++;
      if (out_valid_o !== 1'b1 || out_id_o !== 4'd9 || out_instr_o !== 32'h99990009 ||
          out_rs_o !== rsOf(32'h99990009) || out_mode_o !== 2'd1)
        $display("[TB] FAIL bp_hold%0d: got valid %0h id %0h instr %0h mode %0h expected valid 1 id 9 instr 99990009 mode 1",
                 b, out_valid_o, out_id_o, out_instr_o, out_mode_o);
      else nPass++;
      idle();
      if (b == 1) begin
        drivePush(4'd10, 32'hAAAA000A);
        driveCommit(4'd10, 1'b0);
      end
      tick();
    end
    nChecks++; if (out_id_o !== 4'd9 || count_o !== 3'd2) $display("[TB] FAIL bp_before: got id %0h count %0h expected id 9 count 2", out_id_o, count_o); else nPass++;
    idle();
    out_ready_i = 1'b1;
    tick();
    nChecks++; if (out_valid_o !== 1'b1 || out_id_o !== 4'd10 || count_o !== 3'd1) $display("[TB] FAIL bp_onepop: got valid %0h id %0h count %0h expected valid 1 id a count 1", out_valid_o, out_id_o, count_o); else nPass++;
    idle();
    tick();
    nChecks++; if (out_id_o !== 4'd10 || count_o !== 3'd1) $display("[TB] FAIL bp_stay: got id %0h count %0h expected id a count 1", out_id_o, count_o); else nPass++;
    idle();
    out_ready_i = 1'b1;
    tick();
    nChecks++; if (count_o !== 3'd0) $display("[TB] FAIL bp_count0: got %0h expected 0", count_o); else nPass++;
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    drivePush(4'd1, 32'h0000F001);
    tick();
    idle();
    drivePush(4'd2, 32'h0000F002);
    driveCommit(4'd2, 1'b0);
    tick();
    idle();
    drivePush(4'd3, 32'h0000F003);
    tick();
    idle();
    nChecks++; if (count_o !== 3'd3) $display("[TB] FAIL rm_count3: got %0h expected 3", count_o); else nPass++;
    #2 rst_ni = 1'b0;
    #1;
    nChecks++; if (count_o !== 3'd0) $display("[TB] FAIL rm_count0: got %0h expected 0", count_o); else nPass++;
    nChecks++; if (out_valid_o !== 1'b0) $display("[TB] FAIL rm_valid: got %0h expected 0", out_valid_o); else nPass++;
    nChecks++; if (in_ready_o !== 1'b1) $display("[TB] FAIL rm_ready: got %0h expected 1", in_ready_o); else nPass++;
    #2 rst_ni = 1'b1;
    tick();
    drivePush(4'd2, 32'h0000E002);
    tick();
    for (int c = 1; c <= 3; c++) begin
      nChecks++; if (out_valid_o !== 1'b0 || count_o !== 3'd1) $display("[TB] FAIL rm_wait%0d: got valid %0h count %0h expected 0 1", c, out_valid_o, count_o); else nPass++;
      idle();
      if (c == 3) driveCommit(4'd2, 1'b0);
      tick();
    end
    nChecks++; if (out_valid_o !== 1'b1 || out_id_o !== 4'd2 || out_instr_o !== 32'h0000E002) $display("[TB] FAIL rm_present: got valid %0h id %0h instr %0h expected 1 2 e002", out_valid_o, out_id_o, out_instr_o); else nPass++;
    idle();
    out_ready_i = 1'b1;
    tick();
    nChecks++; if (count_o !== 3'd0) $display("[TB] FAIL rm_drain: got %0h expected 0", count_o); else nPass++;
    idle();
  endtask

  // Run every scenario in order, then report.
  initial begin
    rst_ni      = 1'b0;
    in_rs_i     = '0;
    in_instr_i  = '0;
    in_id_i     = '0;
    in_mode_i   = '0;
    commit_id_i = '0;
    idle();
    test_reset();
    test_pass_through();
    test_kill_drop();
    test_late_commit();
    test_full_wrap();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/fpu_ss_commit_buffer.md
Name: fpu_ss_commit_buffer

Overview:
- Buffers instructions accepted on the cv-x-if issue interface (rs operands, instr, id, mode) until the core commits or kills them.
- Sits between the issue handshake logic and the FPU_SS decoder/fpnew dispatch stage.
- Releases the oldest entry downstream only once it is committed.
- Discards killed entries silently, preserving program order.

Parameters:
- DEPTH, 4, number of buffered instructions (power of two, >=2).
- ID_WIDTH, 4, width of the instruction id (matches X_ID_WIDTH).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- in_valid_i  input  1  issued instruction available.
- in_ready_o  output  1  buffer can accept.
- in_rs_i  input  96  three 32-bit source operands {rs2,rs1,rs0}.
- in_instr_i  input  32  instruction word.
- in_id_i  input  ID_WIDTH  instruction id.
- in_mode_i  input  2  privilege mode.
- commit_valid_i  input  1  commit transaction valid.
- commit_id_i  input  ID_WIDTH  id being committed/killed.
- commit_kill_i  input  1  1 = kill, 0 = commit.
- out_valid_o  output  1  head entry committed and presented.
- out_ready_i  input  1  downstream accepts.
- out_rs_o  output  96  head operands.
- out_instr_o  output  32  head instruction.
- out_id_o  output  ID_WIDTH  head id.
- out_mode_o  output  2  head mode.
- count_o  output  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Storage:
  - Circular FIFO with read/write pointers of $clog2(DEPTH) bits plus a wrap bit.
  - Full = pointers equal with differing wrap bits; empty = equal with equal wrap bits.
- Push:
  - in_ready_o = !full (registered state only; no combinational path from out_ready_i).
  - Push when in_valid_i && in_ready_o.
- Commit tracking:
  - Two 2^ID_WIDTH-bit registers, committed_q and killed_q, indexed by id.
  - commit_valid_i sets committed_q[commit_id_i] if !commit_kill_i, else sets killed_q[commit_id_i].
  - Repeated commits are idempotent.
  - A commit may arrive in the same cycle as the push of that id, or any later cycle.
- Head resolution, head id h, evaluated on registered state:
  - committed_q[h] && !killed_q[h]: out_valid_o=1. On out_ready_i, pop and clear both bits for h.
  - killed_q[h]: out_valid_o=0. Pop (drop) this cycle and clear both bits for h.
  - Neither bit set: out_valid_o=0, wait.
  - Kill takes priority if both bits are set.
- Latency: an entry pushed in cycle N with commit in cycle N reaches out_valid_o in cycle N+1 at the earliest.
- Output stability: out_* are driven from the head entry. While out_valid_o=1 and out_ready_i=0, out_* hold stable.
- Simultaneous set/clear of the same id bit: set wins (a new instance of the id is being committed).
- Simultaneous push and pop (or drop): both occur. count_o is unchanged; pointers both advance, wrapping modulo DEPTH.
- Pop while full: in_ready_o stays 0 that cycle and becomes 1 the next cycle.
- Reset (asynchronous, any time including mid-operation):
  - Pointers and count_o go to 0; committed_q and killed_q go to 0.
  - in_ready_o=1, out_valid_o=0.
  - Storage contents are don't-care, and out_* data is don't-care while out_valid_o=0.
- count_o = number of entries currently stored, 0..DEPTH.

Test Plan:
- Basic pass-through: push id 3 (instr 0x00B57053) in cycle 0, commit id 3 in cycle 0 -> out_valid_o=1 in cycle 1 with out_id_o=3 and out_instr_o=0x00B57053; count_o returns 0 after out_ready_i.
- Kill drop: push ids 1,2; kill id 1, commit id 2 -> id 1 never appears on the output; id 2 presented with out_valid_o=1 exactly one cycle after the drop cycle.
- Ordering under late commit: push ids 5,6; commit 6 at cycle 2 and 5 at cycle 6 -> out_valid_o stays 0 until cycle 7, then id 5 and id 6 are presented in order.
- Full/wrap: DEPTH=4, push ids 0..3 with no commits -> in_ready_o=0 and count_o=4. Commit 0 and hold out_ready_i=1 while asserting a push of id 4 -> id 0 pops, in_ready_o=1 the next cycle, id 4 accepted. After 3 more pop/push pairs the pointers have wrapped and data stays in order.
- Backpressure: head committed, out_ready_i=0 for 5 cycles -> out_valid_o and out_* are stable for all 5 cycles; a single pop on the first out_ready_i=1 cycle.
- Reset mid-operation: rst_ni low with 3 entries buffered and id 2 committed -> immediately count_o=0, out_valid_o=0, in_ready_o=1. After release, a new push of id 2 is not presented until it is committed again.
